// File: rtl/btle_phy_seq.sv
// btle_phy_seq: hop-table driven TX/RX sequencer for a BLE PHY.
// Steps through a small channel table. On each channel it loads the channel,
// then transmits or listens. It can optionally turn around once, after the
// inter-frame space, before moving on to the next slot.
// Optional feature macro: BTLE_PHY_SEQ_STATS_EN adds saturating 16-bit counters
// for CRC_OK, CRC_FAIL and TIMEOUT events.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cmd_start; hop table writable
// LOAD_CH   | one cycle: present table[slot_index] and pulse the load strobe
// TX_RUN    | transmitting; waits for tx_iq_valid_last
// TIFS      | inter-frame gap of TIFS_CYCLES before the opposite direction
// RX_LISTEN | receiver on, waiting for a hit; optional timeout
// RX_DECODE | receiver on, waiting for the end of decode
// NEXT_CH   | advance or wrap slot_index, or finish
// DONE      | sequence complete; hop table writable, may restart
module btle_phy_seq #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int NUM_CHANNEL_SLOT         = 4,
    parameter int TIMER_BIT_WIDTH          = 16,
    parameter int TIFS_CYCLES              = 1200,
    localparam int SLOT_W                  = $clog2(NUM_CHANNEL_SLOT)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_ch_wr,
    input  logic [SLOT_W-1:0]                   cfg_ch_addr,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cfg_ch_data,
    input  logic [SLOT_W:0]                     cfg_num_ch,
    input  logic                                cfg_loop,
    input  logic                                cfg_auto_turn,
    input  logic [TIMER_BIT_WIDTH-1:0]          cfg_rx_timeout,
    input  logic                                cmd_start,
    input  logic                                cmd_mode,
    input  logic                                cmd_abort,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
    output logic                                tx_channel_number_load,
    output logic                                tx_start,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
    output logic                                rx_enable,
    input  logic                                tx_iq_valid_last,
    input  logic                                rx_hit_flag,
    input  logic                                rx_decode_end,
    input  logic                                rx_crc_ok,
    output logic                                busy,
    output logic [2:0]                          state,
    output logic [SLOT_W-1:0]                   slot_index,
    output logic                                event_valid,
    output logic [2:0]                          event_code
`ifdef BTLE_PHY_SEQ_STATS_EN
    ,
    output logic [15:0]                         stat_crc_ok,
    output logic [15:0]                         stat_crc_fail,
    output logic [15:0]                         stat_timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_CH   = 3'd1,
        S_TX_RUN    = 3'd2,
        S_TIFS      = 3'd3,
        S_RX_LISTEN = 3'd4,
        S_RX_DECODE = 3'd5,
        S_NEXT_CH   = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    localparam logic [2:0] EV_TX_DONE  = 3'd0;
    localparam logic [2:0] EV_CRC_OK   = 3'd1;
    localparam logic [2:0] EV_CRC_FAIL = 3'd2;
    localparam logic [2:0] EV_TIMEOUT  = 3'd3;
    localparam logic [2:0] EV_ABORT    = 3'd4;
    localparam logic [2:0] EV_SEQ_DONE = 3'd5;

    localparam logic [TIMER_BIT_WIDTH-1:0] TMR_ONE   = TIMER_BIT_WIDTH'(1);
    localparam logic [TIMER_BIT_WIDTH-1:0] TIFS_LOAD = TIMER_BIT_WIDTH'(TIFS_CYCLES);
    localparam logic [SLOT_W:0]            NUM_SLOTS = (SLOT_W+1)'(NUM_CHANNEL_SLOT);
    localparam logic [SLOT_W-1:0]          SLOT_ONE  = SLOT_W'(1);

    state_t                              state_q, state_nxt;
    logic [SLOT_W-1:0]                   slot_q, slot_nxt;
    logic [TIMER_BIT_WIDTH-1:0]          timer_q, timer_nxt;
    logic                                turned_q, turned_nxt;
    logic                                mode_q, mode_nxt;
    logic                                tifs_to_rx_q, tifs_to_rx_nxt;
    logic                                ev_valid_nxt;
    logic [2:0]                          ev_code_nxt;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] hop_tab [NUM_CHANNEL_SLOT];
    logic                                abort_hit, start_accept, turn_ok, tab_open;
    logic [SLOT_W:0]                     num_eff, slot_last;

    assign tab_open     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign abort_hit    = cmd_abort && (state_q != S_IDLE);
    assign start_accept = cmd_start && tab_open && !abort_hit;
    assign turn_ok      = cfg_auto_turn && !turned_q;

    // Effective slot count: 0 behaves as 1, anything above the table depth is clamped.
    always_comb begin
        num_eff = cfg_num_ch;
        if (cfg_num_ch == '0)
            num_eff = {{SLOT_W{1'b0}}, 1'b1};
        else if (cfg_num_ch > NUM_SLOTS)
            num_eff = NUM_SLOTS;
        slot_last = num_eff - {{SLOT_W{1'b0}}, 1'b1};
    end

    // Next-state, timer and event selection; abort outranks every other event.
    always_comb begin
        state_nxt      = state_q;
        slot_nxt       = slot_q;
        timer_nxt      = timer_q;
        turned_nxt     = turned_q;
        mode_nxt       = mode_q;
        tifs_to_rx_nxt = tifs_to_rx_q;
        ev_valid_nxt   = 1'b0;
        ev_code_nxt    = EV_TX_DONE;
        if (abort_hit) begin
            ev_valid_nxt = 1'b1;
            ev_code_nxt  = EV_ABORT;
            state_nxt    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_accept) begin
                        mode_nxt   = cmd_mode;
                        slot_nxt   = '0;
                        turned_nxt = 1'b0;
                        state_nxt  = S_LOAD_CH;
                    end
                end
                S_LOAD_CH: state_nxt = mode_q ? S_RX_LISTEN : S_TX_RUN;
                S_TX_RUN: begin
                    if (tx_iq_valid_last) begin
                        ev_valid_nxt = 1'b1;
                        ev_code_nxt  = EV_TX_DONE;
                        if (turn_ok) begin
                            turned_nxt     = 1'b1;
                            tifs_to_rx_nxt = 1'b1;
                            state_nxt      = S_TIFS;
                        end else begin
                            state_nxt = S_NEXT_CH;
                        end
                    end
                end
                S_TIFS: begin
                    if (timer_q <= TMR_ONE)
                        state_nxt = tifs_to_rx_q ? S_RX_LISTEN : S_TX_RUN;
                    else
                        timer_nxt = timer_q - TMR_ONE;
                end
                S_RX_LISTEN: begin
                    // A zero timer means the listen window is unlimited.
                    if (rx_hit_flag) begin
                        state_nxt = S_RX_DECODE;
                    end else if (timer_q == TMR_ONE) begin
                        ev_valid_nxt = 1'b1;
                        ev_code_nxt  = EV_TIMEOUT;
                        state_nxt    = S_NEXT_CH;
                    end else if (timer_q != '0) begin
                        timer_nxt = timer_q - TMR_ONE;
                    end
                end
                S_RX_DECODE: begin
                    if (rx_decode_end) begin
                        ev_valid_nxt = 1'b1;
                        if (rx_crc_ok) begin
                            ev_code_nxt = EV_CRC_OK;
                            if (turn_ok) begin
                                turned_nxt     = 1'b1;
                                tifs_to_rx_nxt = 1'b0;
                                state_nxt      = S_TIFS;
                            end else begin
                                state_nxt = S_NEXT_CH;
                            end
                        end else begin
                            ev_code_nxt = EV_CRC_FAIL;
                            state_nxt   = S_NEXT_CH;
                        end
                    end
                end
                S_NEXT_CH: begin
                    turned_nxt = 1'b0;
                    if ({1'b0, slot_q} < slot_last) begin
                        slot_nxt  = slot_q + SLOT_ONE;
                        state_nxt = S_LOAD_CH;
                    end else if (cfg_loop) begin
                        slot_nxt  = '0;
                        state_nxt = S_LOAD_CH;
                    end else begin
                        ev_valid_nxt = 1'b1;
                        ev_code_nxt  = EV_SEQ_DONE;
                        state_nxt    = S_DONE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        if (state_nxt == S_RX_LISTEN && state_q != S_RX_LISTEN)
            timer_nxt = cfg_rx_timeout;
        if (state_nxt == S_TIFS && state_q != S_TIFS)
            timer_nxt = TIFS_LOAD;
    end

    // Sequencer registers; PHY strobes are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                <= S_IDLE;
            slot_q                 <= '0;
            timer_q                <= '0;
            turned_q               <= 1'b0;
            mode_q                 <= 1'b0;
            tifs_to_rx_q           <= 1'b0;
            tx_start               <= 1'b0;
            tx_channel_number_load <= 1'b0;
            tx_channel_number      <= '0;
            rx_channel_number      <= '0;
            rx_enable              <= 1'b0;
            event_valid            <= 1'b0;
            event_code             <= '0;
        end else begin
            state_q                <= state_nxt;
            slot_q                 <= slot_nxt;
            timer_q                <= timer_nxt;
            turned_q               <= turned_nxt;
            mode_q                 <= mode_nxt;
            tifs_to_rx_q           <= tifs_to_rx_nxt;
            tx_start               <= (state_nxt == S_TX_RUN) && (state_q != S_TX_RUN);
            tx_channel_number_load <= (state_nxt == S_LOAD_CH);
            if (state_nxt == S_LOAD_CH) begin
                tx_channel_number <= hop_tab[slot_nxt];
                rx_channel_number <= hop_tab[slot_nxt];
            end
            rx_enable   <= (state_nxt == S_RX_LISTEN) || (state_nxt == S_RX_DECODE);
            event_valid <= ev_valid_nxt;
            event_code  <= ev_code_nxt;
        end
    end

    // Hop table: writable only while the sequencer is parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNEL_SLOT; i++)
                hop_tab[i] <= '0;
        end else if (cfg_ch_wr && tab_open) begin
            hop_tab[cfg_ch_addr] <= cfg_ch_data;
        end
    end

    assign busy       = !tab_open;
    assign state      = state_q;
    assign slot_index = slot_q;

`ifdef BTLE_PHY_SEQ_STATS_EN
    // Saturating event counters, cleared when a new sequence starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_crc_ok   <= '0;
            stat_crc_fail <= '0;
            stat_timeout  <= '0;
        end else if (start_accept) begin
            stat_crc_ok   <= '0;
            stat_crc_fail <= '0;
            stat_timeout  <= '0;
        end else if (ev_valid_nxt) begin
            if (ev_code_nxt == EV_CRC_OK && stat_crc_ok != 16'hFFFF)
                stat_crc_ok <= stat_crc_ok + 16'd1;
            if (ev_code_nxt == EV_CRC_FAIL && stat_crc_fail != 16'hFFFF)
                stat_crc_fail <= stat_crc_fail + 16'd1;
            if (ev_code_nxt == EV_TIMEOUT && stat_timeout != 16'hFFFF)
                stat_timeout <= stat_timeout + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btle_phy_seq.sv
// Directed bench for btle_phy_seq with an event scoreboard.
// Expected event codes are queued as stimulus is driven and are popped when event_valid fires.
module tb_btle_phy_seq;
    localparam int CW = 6;
    localparam int SW = 2;
    localparam int TW = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_TX = 3'd2, S_TIFS = 3'd3;
    localparam logic [2:0] S_LISTEN = 3'd4, S_DECODE = 3'd5, S_NEXT = 3'd6, S_DONE = 3'd7;
    localparam logic [2:0] EV_TX_DONE = 3'd0, EV_CRC_OK = 3'd1, EV_CRC_FAIL = 3'd2;
    localparam logic [2:0] EV_TIMEOUT = 3'd3, EV_ABORT = 3'd4, EV_SEQ_DONE = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_ch_wr = 1'b0;
    logic [SW-1:0] cfg_ch_addr = '0;
    logic [CW-1:0] cfg_ch_data = '0;
    logic [SW:0]   cfg_num_ch = '0;
    logic          cfg_loop = 1'b0;
    logic          cfg_auto_turn = 1'b0;
    logic [TW-1:0] cfg_rx_timeout = '0;
    logic          cmd_start = 1'b0;
    logic          cmd_mode = 1'b0;
    logic          cmd_abort = 1'b0;
    logic          tx_iq_valid_last = 1'b0;
    logic          rx_hit_flag = 1'b0;
    logic          rx_decode_end = 1'b0;
    logic          rx_crc_ok = 1'b0;
    logic [CW-1:0] tx_channel_number, rx_channel_number;
    logic          tx_channel_number_load, tx_start, rx_enable, busy, event_valid;
    logic [2:0]    state, event_code;
    logic [SW-1:0] slot_index;
`ifdef BTLE_PHY_SEQ_STATS_EN
    logic [15:0]   stat_crc_ok, stat_crc_fail, stat_timeout;
`endif

    int         n_checks = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    logic [2:0] exp_q[$];

    btle_phy_seq #(
        .CHANNEL_NUMBER_BIT_WIDTH(CW),
        .NUM_CHANNEL_SLOT(4),
        .TIMER_BIT_WIDTH(TW),
        .TIFS_CYCLES(1200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_ch_wr(cfg_ch_wr),
        .cfg_ch_addr(cfg_ch_addr),
        .cfg_ch_data(cfg_ch_data),
        .cfg_num_ch(cfg_num_ch),
        .cfg_loop(cfg_loop),
        .cfg_auto_turn(cfg_auto_turn),
        .cfg_rx_timeout(cfg_rx_timeout),
        .cmd_start(cmd_start),
        .cmd_mode(cmd_mode),
        .cmd_abort(cmd_abort),
        .tx_channel_number(tx_channel_number),
        .tx_channel_number_load(tx_channel_number_load),
        .tx_start(tx_start),
        .rx_channel_number(rx_channel_number),
        .rx_enable(rx_enable),
        .tx_iq_valid_last(tx_iq_valid_last),
        .rx_hit_flag(rx_hit_flag),
        .rx_decode_end(rx_decode_end),
        .rx_crc_ok(rx_crc_ok),
        .busy(busy),
        .state(state),
        .slot_index(slot_index),
        .event_valid(event_valid),
        .event_code(event_code)
`ifdef BTLE_PHY_SEQ_STATS_EN
        ,
        .stat_crc_ok(stat_crc_ok),
        .stat_crc_fail(stat_crc_fail),
        .stat_timeout(stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (state !== s && k < budget);
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic wr(input int a, input int d);
        cfg_ch_wr   = 1'b1;
        cfg_ch_addr = SW'(a);
        cfg_ch_data = CW'(d);
        tick();
        cfg_ch_wr   = 1'b0;
    endtask

    task automatic pulse_start(input logic m);
        cmd_mode  = m;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Scoreboard: every event the DUT reports must match the oldest queued expectation.
    always @(negedge clk) begin
        if (event_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_event: observed code %0d expected no event", event_code);
            end
            if (exp_q.size() > 0) check("event_code", 32'(event_code), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int n;
        tick(2);
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_busy", 32'(busy), 0);
        check("rst_event_valid", 32'(event_valid), 0);
        check("rst_rx_enable", 32'(rx_enable), 0);
        check("rst_tx_ch", 32'(tx_channel_number), 0);
        rst = 1'b0;
        tick();

        // Three-slot TX sequence, with a table write attempted while busy.
        cfg_num_ch = 3'd3;
        wr(0, 37); wr(1, 38); wr(2, 39);
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_state(S_LOAD, 20, "wait_load");
            check("load_pulse", 32'(tx_channel_number_load), 1);
            check("tx_ch", 32'(tx_channel_number), 32'(37 + i));
            check("rx_ch", 32'(rx_channel_number), 32'(37 + i));
            tick();
            check("tx_start_first", 32'(tx_start), 1);
            check("state_tx_run", 32'(state), 32'(S_TX));
            tick();
            check("tx_start_one_cycle", 32'(tx_start), 0);
            if (i == 0) begin
                wr(2, 11);
                tick(97);
            end else begin
                tick(98);
            end
            tx_iq_valid_last = 1'b1;
            exp_q.push_back(EV_TX_DONE);
            if (i == 2) exp_q.push_back(EV_SEQ_DONE);
            tick();
            tx_iq_valid_last = 1'b0;
        end
        wait_state(S_DONE, 10, "seq_done_state");
        check("done_busy", 32'(busy), 0);

        // RX first with turnaround: CRC_OK, TIFS gap, then TX.
        cfg_num_ch    = 3'd1;
        cfg_auto_turn = 1'b1;
        pulse_start(1'b1);
        check("rx_load_ch", 32'(rx_channel_number), 37);
        wait_state(S_LISTEN, 5, "wait_listen");
        check("listen_rx_enable", 32'(rx_enable), 1);
        tick(49);
        rx_hit_flag = 1'b1;
        tick();
        rx_hit_flag = 1'b0;
        check("hit_to_decode", 32'(state), 32'(S_DECODE));
        check("decode_rx_enable", 32'(rx_enable), 1);
        tick(3);
        rx_decode_end = 1'b1;
        rx_crc_ok     = 1'b1;
        exp_q.push_back(EV_CRC_OK);
        tick();
        rx_decode_end = 1'b0;
        rx_crc_ok     = 1'b0;
        n = 0;
        while (state === S_TIFS && rx_enable === 1'b0 && n < 2000) begin
            n++;
            tick();
        end
        check("tifs_len", 32'(n), 1200);
        check("tifs_exit_tx", 32'(state), 32'(S_TX));
        check("tifs_tx_start", 32'(tx_start), 1);
        tick(10);
        tx_iq_valid_last = 1'b1;
        exp_q.push_back(EV_TX_DONE);
        exp_q.push_back(EV_SEQ_DONE);
        tick();
        tx_iq_valid_last = 1'b0;
        check("no_second_turn", 32'(state), 32'(S_NEXT));
        wait_state(S_DONE, 5, "turn_done");

        // Listen timeout after exactly 300 cycles, then a hit on the expiry cycle.
        cfg_auto_turn  = 1'b0;
        cfg_rx_timeout = 16'd300;
        exp_q.push_back(EV_TIMEOUT);
        exp_q.push_back(EV_SEQ_DONE);
        pulse_start(1'b1);
        wait_state(S_LISTEN, 5, "wait_listen_to");
        tick(299);
        check("timeout_early", 32'(event_valid), 0);
        check("timeout_still_listen", 32'(state), 32'(S_LISTEN));
        tick();
        check("timeout_valid", 32'(event_valid), 1);
        check("timeout_code", 32'(event_code), 32'(EV_TIMEOUT));
        check("timeout_next_ch", 32'(state), 32'(S_NEXT));
        wait_state(S_DONE, 5, "timeout_done");
        pulse_start(1'b1);
        wait_state(S_LISTEN, 5, "wait_listen_hit");
        tick(299);
        rx_hit_flag = 1'b1;
        tick();
        rx_hit_flag = 1'b0;
        check("hit_beats_timeout", 32'(state), 32'(S_DECODE));
        check("hit_no_event", 32'(event_valid), 0);
        rx_decode_end = 1'b1;
        exp_q.push_back(EV_CRC_FAIL);
        exp_q.push_back(EV_SEQ_DONE);
        tick();
        rx_decode_end = 1'b0;
        wait_state(S_DONE, 5, "crc_fail_done");

        // Looping two-slot TX, abort in LOAD_CH, abort ignored in IDLE.
        cfg_num_ch     = 3'd2;
        cfg_loop       = 1'b1;
        cfg_rx_timeout = '0;
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wait_state(S_LOAD, 20, "loop_load");
            check("loop_slot", 32'(slot_index), 32'(i % 2));
            check("loop_ch", 32'(tx_channel_number), 32'((i % 2) ? 38 : 37));
            if (i < 4) begin
                tick();
                tx_iq_valid_last = 1'b1;
                exp_q.push_back(EV_TX_DONE);
                tick();
                tx_iq_valid_last = 1'b0;
            end
        end
        cmd_abort = 1'b1;
        exp_q.push_back(EV_ABORT);
        tick();
        check("abort_to_idle", 32'(state), 32'(S_IDLE));
        tick();
        cmd_abort = 1'b0;
        check("idle_abort_no_event", 32'(event_valid), 0);
        check("idle_abort_state", 32'(state), 32'(S_IDLE));

        // Abort coincident with decode end: only ABORT.
        cfg_loop = 1'b0;
        pulse_start(1'b1);
        wait_state(S_LISTEN, 5, "wait_listen_ab");
        rx_hit_flag = 1'b1;
        tick();
        rx_hit_flag   = 1'b0;
        rx_decode_end = 1'b1;
        rx_crc_ok     = 1'b1;
        cmd_abort     = 1'b1;
        exp_q.push_back(EV_ABORT);
        tick();
        rx_decode_end = 1'b0;
        rx_crc_ok     = 1'b0;
        cmd_abort     = 1'b0;
        check("abort_decode_idle", 32'(state), 32'(S_IDLE));
        check("abort_rx_enable", 32'(rx_enable), 0);
        check("abort_code", 32'(event_code), 32'(EV_ABORT));
        tick();
        check("abort_single_event", 32'(event_valid), 0);

        // Reset during TIFS clears outputs immediately; table comes back zeroed.
        cfg_num_ch    = 3'd1;
        cfg_auto_turn = 1'b1;
        pulse_start(1'b0);
        tick();
        tx_iq_valid_last = 1'b1;
        exp_q.push_back(EV_TX_DONE);
        tick();
        tx_iq_valid_last = 1'b0;
        check("enter_tifs", 32'(state), 32'(S_TIFS));
        tick(5);
        rst = 1'b1;
        #1;
        check("rst_tifs_state", 32'(state), 32'(S_IDLE));
        check("rst_tifs_busy", 32'(busy), 0);
        check("rst_tifs_tx_ch", 32'(tx_channel_number), 0);
        check("rst_tifs_rx_ch", 32'(rx_channel_number), 0);
        check("rst_tifs_slot", 32'(slot_index), 0);
        tick();
        rst = 1'b0;
        pulse_start(1'b1);
        check("table_cleared", 32'(tx_channel_number), 0);
        wait_state(S_LISTEN, 5, "wait_listen_rst");
        check("listen_before_rst", 32'(rx_enable), 1);
        rst = 1'b1;
        #1;
        check("rst_drops_rx_enable", 32'(rx_enable), 0);
        check("rst_listen_state", 32'(state), 32'(S_IDLE));
        tick();
        rst = 1'b0;
        tick();

`ifdef BTLE_PHY_SEQ_STATS_EN
        // Drive 70000 CRC_FAIL events to saturate the counter, then restart to clear it.
        cfg_num_ch    = 3'd1;
        cfg_loop      = 1'b1;
        cfg_auto_turn = 1'b0;
        rx_hit_flag   = 1'b1;
        rx_decode_end = 1'b1;
        rx_crc_ok     = 1'b0;
        pulse_start(1'b1);
        for (int i = 0; i < 70000; i++) begin
            exp_q.push_back(EV_CRC_FAIL);
            wait_state(S_DECODE, 10, "stat_decode");
        end
        tick(2);
        check("stat_crc_fail_sat", 32'(stat_crc_fail), 65535);
        check("stat_crc_ok_zero", 32'(stat_crc_ok), 0);
        cmd_abort = 1'b1;
        exp_q.push_back(EV_ABORT);
        tick();
        cmd_abort     = 1'b0;
        rx_hit_flag   = 1'b0;
        rx_decode_end = 1'b0;
        cfg_loop      = 1'b0;
        pulse_start(1'b0);
        check("stat_cleared", 32'(stat_crc_fail), 0);
        cmd_abort = 1'b1;
        exp_q.push_back(EV_ABORT);
        tick();
        cmd_abort = 1'b0;
        tick(2);
`endif

        tick(3);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/btle_phy_seq.md
BTLE_PHY_SEQ -- requirements
Module: btle_phy_seq

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6, width of channel numbers.
REQ-002 SHALL have parameter NUM_CHANNEL_SLOT, default 4, depth of the hop table (power of two, 2..64).
REQ-003 SHALL have parameter TIMER_BIT_WIDTH, default 16, width of the turnaround and timeout counters.
REQ-004 SHALL have parameter TIFS_CYCLES, default 1200, inter-frame space in clk cycles (150 us at 8 MHz).
REQ-005 SHALL have ports: clk input 1, sole clock; rst input 1, reset, asynchronous, active-high.
REQ-006 SHALL have cfg ports: cfg_ch_wr in 1, table write strobe; cfg_ch_addr in log2(NUM_CHANNEL_SLOT), slot; cfg_ch_data in CHANNEL_NUMBER_BIT_WIDTH, channel; cfg_num_ch in log2(NUM_CHANNEL_SLOT)+1, slots used; cfg_loop in 1, wrap forever; cfg_auto_turn in 1, enable turnaround; cfg_rx_timeout in TIMER_BIT_WIDTH, listen limit.
REQ-007 SHALL have command ports: cmd_start in 1, pulse; cmd_mode in 1, 0 = TX first, 1 = RX first; cmd_abort in 1, pulse.
REQ-008 SHALL have PHY-side ports: tx_channel_number out CHANNEL_NUMBER_BIT_WIDTH; tx_channel_number_load out 1; tx_start out 1; rx_channel_number out CHANNEL_NUMBER_BIT_WIDTH; rx_enable out 1; tx_iq_valid_last in 1; rx_hit_flag in 1; rx_decode_end in 1; rx_crc_ok in 1.
REQ-009 SHALL have status ports: busy out 1; state out 3; slot_index out log2(NUM_CHANNEL_SLOT); event_valid out 1; event_code out 3.

Function
REQ-010 States SHALL be IDLE=0, LOAD_CH=1, TX_RUN=2, TIFS=3, RX_LISTEN=4, RX_DECODE=5, NEXT_CH=6, DONE=7; state output SHALL equal the current encoding.
REQ-011 Hop-table writes SHALL take effect only in IDLE or DONE; writes in other states are ignored.
REQ-012 IDLE/DONE + cmd_start SHALL latch cmd_mode, clear slot_index and the turned flag, and enter LOAD_CH.
REQ-013 LOAD_CH (1 cycle) SHALL drive table[slot_index] on both channel outputs and pulse tx_channel_number_load.
REQ-013a LOAD_CH SHALL then go to TX_RUN if mode=0, else to RX_LISTEN.
REQ-014 tx_start SHALL pulse for exactly one cycle on the first cycle of TX_RUN.
REQ-014a TX_RUN SHALL wait for tx_iq_valid_last, then emit event TX_DONE(0).
REQ-015 RX_LISTEN SHALL hold rx_enable=1 and load the timer with cfg_rx_timeout on entry; the timer SHALL decrement each cycle.
REQ-015a In RX_LISTEN, rx_hit_flag SHALL move to RX_DECODE; timer reaching 0 without a hit SHALL emit TIMEOUT(3) and go to NEXT_CH.
REQ-015b cfg_rx_timeout=0 SHALL mean no timeout; a hit and expiry in the same cycle SHALL resolve to the hit.
REQ-016 RX_DECODE SHALL hold rx_enable=1 until rx_decode_end, then emit CRC_OK(1) or CRC_FAIL(2) according to rx_crc_ok in that cycle.
REQ-017 Turnaround SHALL occur when cfg_auto_turn=1 and turned=0, after TX_DONE or after CRC_OK only; it SHALL set turned=1 and enter TIFS.
REQ-017a Without turnaround, the block SHALL go to NEXT_CH.
REQ-017b TIFS SHALL last exactly TIFS_CYCLES cycles with rx_enable=0, then enter the opposite direction (TX_RUN or RX_LISTEN).
REQ-018 NEXT_CH SHALL clear turned.
REQ-018a If slot_index < max(cfg_num_ch,1)-1, NEXT_CH SHALL increment slot_index and go to LOAD_CH.
REQ-018b Otherwise, if cfg_loop=1, NEXT_CH SHALL wrap slot_index to 0 and go to LOAD_CH; else it SHALL emit SEQ_DONE(5) and go to DONE.
REQ-019 cmd_abort in any non-IDLE state SHALL have priority over every simultaneous event, emit ABORT(4), deassert rx_enable, and enter IDLE on the next cycle.
REQ-019a cmd_abort in IDLE SHALL be ignored.
REQ-020 event_valid SHALL be a registered one-cycle pulse qualifying event_code; at most one event SHALL be emitted per cycle.
REQ-021 busy SHALL be 1 in every state except IDLE and DONE.

Reset
REQ-022 rst SHALL asynchronously force IDLE, and force slot_index, timer, turned, tx_start, tx_channel_number_load, rx_enable, event_valid, event_code, and both channel outputs to 0; the hop table SHALL reset to all 0.
REQ-022a rst asserted mid-sequence SHALL drop rx_enable and tx_start in the same cycle, with no event emitted.

Configuration
REQ-023 With macro BTLE_PHY_SEQ_STATS_EN defined, the block SHALL add 16-bit outputs stat_crc_ok, stat_crc_fail, and stat_timeout.
REQ-023a Each stat counter SHALL increment on its event, saturate at 65535, clear on rst and on cmd_start from IDLE/DONE, and never wrap.
REQ-023b Without BTLE_PHY_SEQ_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Table {37,38,39}, cfg_num_ch=3, mode=0, auto_turn=0, cfg_loop=0, each tx_iq_valid_last 100 cycles after tx_start -> 3 TX_DONE events, channels 37/38/39 loaded in order, then SEQ_DONE, state=7.
REQ-025 mode=1, auto_turn=1, rx_hit_flag at listen cycle 50, rx_decode_end with rx_crc_ok=1 -> CRC_OK event, exactly 1200 cycles with rx_enable=0, tx_start pulse, TX_DONE, NEXT_CH.
REQ-026 mode=1, cfg_rx_timeout=300, no hit -> TIMEOUT event exactly 300 cycles after RX_LISTEN entry; rx_hit_flag in the expiry cycle -> RX_DECODE with no TIMEOUT.
REQ-027 cfg_num_ch=2, cfg_loop=1 -> slot_index sequence 0,1,0,1...; cmd_abort coincident with rx_decode_end -> only ABORT emitted, IDLE next cycle, rx_enable=0.
REQ-028 rst pulse during TIFS -> all outputs 0 immediately; a table write while busy is ignored (readback after DONE unchanged).
REQ-029 With BTLE_PHY_SEQ_STATS_EN: 70000 CRC_FAIL events -> stat_crc_fail=65535; a new cmd_start clears it to 0.
